register_8b_serializer: RTL
===========================

// Module: register_8b_serializer
// PURPOSE
//  Read-out end of an 8-bit data register path.
//  - Accepts a parallel byte through a valid/ready handshake.
//  - Shifts the byte out one bit per enabled clock, then pulses done.
//  - Sits between the CPU datapath registers and any 1-bit consumer, e.g. a debug/serial output.
// PARAMETERS
//  WIDTH      8   data word width in bits; legal range 2..16
//  LSB_FIRST  1   1: bit 0 goes out first; 0: bit WIDTH-1 goes out first
// PORTS
//  clock         in   1      single system clock, rising edge
//  clear         in   1      asynchronous, active-high reset
//  load_data     in   WIDTH  parallel word to serialize
//  load_valid    in   1      load_data is valid this cycle
//  load_ready    out  1      block can accept a word (IDLE)
//  clock_enable  in   1      shift strobe; the block advances only when this is high
//  serial_out    out  1      current output bit
//  serial_valid  out  1      serial_out holds a live data bit
//  busy          out  1      a word is being shifted out
//  done          out  1      one-cycle pulse after the last bit is consumed
// BEHAVIOUR
//  Reset (clear=1, async)
//  - state=IDLE; shift register and bit counter are 0.
//  - Outputs: serial_out=0, serial_valid=0, busy=0, done=0, load_ready=1.
//  - Clear asserted mid-shift aborts the word immediately. done is not pulsed.
//  States: IDLE, SHIFT (2-state FSM, registered).
//  IDLE
//  - load_ready=1, busy=0, serial_valid=0, serial_out=0.
//  - On a clock edge with load_valid=1:
//    - capture load_data into the shift register;
//    - set count=0; go to SHIFT.
//  - load_valid=0: stay in IDLE.
//  - clock_enable is ignored in IDLE.
//  SHIFT
//  - load_ready=0, busy=1, serial_valid=1.
//  - serial_out = shreg[0] if LSB_FIRST, else shreg[WIDTH-1]. Combinational from the register, so no extra latency.
//  - Edge with clock_enable=1: shift toward the output end, fill with 0, count += 1.
//  - Edge with clock_enable=1 and count==WIDTH-1: last bit consumed. Go to IDLE and pulse done=1 for exactly the next cycle.
//  - Edge with clock_enable=0: hold everything. A stall may last any number of cycles.
//  - load_valid is ignored in SHIFT. No overwrite and no queueing.
//  Latency
//  - Word accepted at edge N: bit 0 is on serial_out in the cycle after edge N.
//  - With clock_enable held high: last bit visible in cycle N+WIDTH; done high in cycle N+WIDTH+1.
//  Simultaneous events
//  - done and load_ready are both 1 in the done cycle.
//  - A load_valid in that cycle is accepted. Back-to-back words therefore have one idle cycle between them.
//  - clear overrides every other input.
//  Counter width: $clog2(WIDTH). Count never exceeds WIDTH-1.
// STRUCTURE
//  Shared defines file serializer_defs.vh holds:
//  - state encodings S_IDLE=1'b0, S_SHIFT=1'b1;
//  - default WIDTH;
//  - the counter-width macro.
//  One sub-module, bit_counter:
//  - parameterized up-counter with async clear, enable, sync zero-load and a terminal-count flag;
//  - one instance drives the count==WIDTH-1 decision.
//  Shift register, FSM and output muxing stay in this module.
// TESTING
//  1. Reset: assert clear for 3 cycles with random inputs.
//     -> load_ready=1, all other outputs 0. No done pulse.
//  2. LSB_FIRST=1, load 8'hA5, clock_enable held 1.
//     -> serial_out 1,0,1,0,0,1,0,1 on cycles N+1..N+8, serial_valid high throughout, done only at N+9.
//  3. LSB_FIRST=0, load 8'h3C, clock_enable toggled 1,0,1,0...
//     -> each bit of 0,0,1,1,1,1,0,0 held 2 cycles; done 1 cycle after the 8th enabled edge.
//  4. Load 8'hFF, then load_valid=1 with 8'h00 during SHIFT.
//     -> 8'h00 ignored, eight 1 bits out, load_ready stays 0 until done.
//  5. Load 8'h81, assert clear after 3 enabled edges.
//     -> immediate IDLE with outputs 0; no done; next load 8'h01 serializes correctly.
//  6. Back-to-back: load 8'h0F, then hold load_valid=1 with 8'hF0.
//     -> second word accepted in the done cycle; 16 bits out with exactly one idle cycle between the words.

Source files
------------

// File: rtl/register_8b_serializer_pkg.sv
// rtl/register_8b_serializer_pkg.sv - shared state encodings, default width and counter sizing
package register_8b_serializer_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // A 1-bit counter is still needed when WIDTH would give $clog2 == 0.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/register_8b_serializer_bit_counter.sv
// rtl/register_8b_serializer_bit_counter.sv - up-counter with async clear, enable, sync zero-load and terminal flag
module bit_counter #(
  parameter int CNT_W    = 3,
  parameter int TERMINAL = 7
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             i_zero,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count,
  output logic             o_terminal
);

  localparam logic [CNT_W-1:0] TC = CNT_W'(TERMINAL);

  logic [CNT_W-1:0] r_count;

  // Zero-load wins over enable so a wrap at the terminal count never escapes.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_count <= '0;
    end else if (i_zero) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count    = r_count;
  assign o_terminal = (r_count == TC);

endmodule

// File: rtl/register_8b_serializer.sv
// rtl/register_8b_serializer.sv - byte-to-bit serializer with valid/ready load and shift strobe
module register_8b_serializer
  import register_8b_serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             clock_enable,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = cnt_width(WIDTH);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_shreg;
  logic             r_done;
  logic [CW-1:0]    w_count;
  logic             w_terminal;
  logic             w_accept;
  logic             w_shift_en;
  logic             w_last;
  logic             w_out_bit;

  assign w_accept   = (r_state == S_IDLE) && load_valid;
  assign w_shift_en = (r_state == S_SHIFT) && clock_enable;
  assign w_last     = w_shift_en && w_terminal;

  bit_counter #(
    .CNT_W    (CW),
    .TERMINAL (WIDTH - 1)
  ) u_bit_counter (
    .clock      (clock),
    .clear      (clear),
    .i_zero     (w_accept | w_last),
    .i_en       (w_shift_en),
    .o_count    (w_count),
    .o_terminal (w_terminal)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (load_valid) w_next_state = S_SHIFT;
      S_SHIFT: if (w_last)     w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Zero fill means the register is already empty when the word completes.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_shreg <= '0;
    end else if (w_accept) begin
      r_shreg <= load_data;
    end else if (w_shift_en) begin
      if (LSB_FIRST) begin
        r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
      end else begin
        r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_last;
    end
  end

  assign w_out_bit    = LSB_FIRST ? r_shreg[0] : r_shreg[WIDTH-1];
  assign busy         = (r_state == S_SHIFT);
  assign serial_valid = busy;
  assign serial_out   = busy & w_out_bit;
  assign load_ready   = (r_state == S_IDLE);
  assign done         = r_done;

  logic w_unused;
  assign w_unused = ^w_count;

endmodule
